// File: rtl/sc_pkt_fifo.sv
// sc_pkt_fifo: single-clock, packet-aware store-and-forward buffer for the sc_* stream bus.
// Only complete packets, those whose eop has been written, are released downstream.
// Packets that overflow the buffer, or that lose their eop, are discarded whole.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   sc_i_d/dval/sop/eop                input stream (sop/eop qualified by dval)
//   sc_o_rdy                           downstream pacing enable (level-sensitive)
//   sc_o_d/dval/sop/eop                output stream, one cycle after the read is issued
//   level                              words held, committed or not (wr_ptr - rd_ptr)
//   drop_cnt                           packets discarded, saturating
//   err_cnt                            orphan words (dval outside a packet), saturating
module sc_pkt_fifo #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 9,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] sc_i_d,
    input  logic          sc_i_dval,
    input  logic          sc_i_sop,
    input  logic          sc_i_eop,
    input  logic          sc_o_rdy,
    output logic [DW-1:0] sc_o_d,
    output logic          sc_o_dval,
    output logic          sc_o_sop,
    output logic          sc_o_eop,
    output logic [AW:0]   level,
    output logic [CW-1:0] drop_cnt,
    output logic [CW-1:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StPkt, StDrop} wr_state_e;

    localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

    // Stored word layout: {sop, eop, data}.
    logic [DW+1:0] mem [2**AW];

    logic [AW:0]   wr_ptr;
    logic [AW:0]   cm_ptr;
    logic [AW:0]   rd_ptr;
    wr_state_e     state;
    logic [DW+1:0] in_word;
    logic          full;
    logic          rd_en;

    assign in_word = {sc_i_sop, sc_i_eop, sc_i_d};
    assign level   = wr_ptr - rd_ptr;
    // Pre-cycle pointers: a read in the same cycle does not make room for the write.
    assign full    = (level == Depth);
    assign rd_en   = sc_o_rdy && (cm_ptr != rd_ptr);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Write side: FSM, write/commit pointers, memory write and discard counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= StIdle;
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else if (sc_i_dval) begin
            case (state)
                StIdle, StDrop: begin
                    if (sc_i_sop) begin
                        if (!full) begin
                            mem[wr_ptr[AW-1:0]] <= in_word;
                            wr_ptr <= wr_ptr + 1'b1;
                            if (sc_i_eop) begin
                                cm_ptr <= wr_ptr + 1'b1;
                                state  <= StIdle;
                            end else begin
                                state <= StPkt;
                            end
                        end else begin
                            drop_cnt <= sat_inc(drop_cnt);
                            state    <= sc_i_eop ? StIdle : StDrop;
                        end
                    end else if (state == StIdle) begin
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                StPkt: begin
                    if (sc_i_sop) begin
                        // Previous packet lost its eop: rewind and start the new one at cm_ptr.
                        // The rewound packet held at least one word, so this slot is free.
                        drop_cnt <= sat_inc(drop_cnt);
                        mem[cm_ptr[AW-1:0]] <= in_word;
                        wr_ptr <= cm_ptr + 1'b1;
                        if (sc_i_eop) begin
                            cm_ptr <= cm_ptr + 1'b1;
                            state  <= StIdle;
                        end
                    end else if (!full) begin
                        mem[wr_ptr[AW-1:0]] <= in_word;
                        wr_ptr <= wr_ptr + 1'b1;
                        if (sc_i_eop) begin
                            cm_ptr <= wr_ptr + 1'b1;
                            state  <= StIdle;
                        end
                    end else begin
                        wr_ptr   <= cm_ptr;
                        drop_cnt <= sat_inc(drop_cnt);
                        state    <= StDrop;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Read side: registered memory read, never passing the commit pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            sc_o_dval <= 1'b0;
            sc_o_sop  <= 1'b0;
            sc_o_eop  <= 1'b0;
            sc_o_d    <= '0;
        end else begin
            sc_o_dval <= rd_en;
            if (rd_en) begin
                rd_ptr   <= rd_ptr + 1'b1;
                sc_o_sop <= mem[rd_ptr[AW-1:0]][DW+1];
                sc_o_eop <= mem[rd_ptr[AW-1:0]][DW];
                sc_o_d   <= mem[rd_ptr[AW-1:0]][DW-1:0];
            end else begin
                // Data holds; framing flags only ever accompany dval.
                sc_o_sop <= 1'b0;
                sc_o_eop <= 1'b0;
            end
        end
    end

endmodule
